// File: rtl/local_net_iface_pkg.sv
// ============================================================================
// Module : local_net_iface_pkg
// Brief  : Shared flit geometry and TX state encoding for the local NI.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package local_net_iface_pkg;

    localparam int C_DW     = `DATA_WIDTH;
    localparam int C_ADDR_W = 3;

    localparam logic [1:0] C_ST_IDLE    = 2'd0;
    localparam logic [1:0] C_ST_SEND    = 2'd1;
    localparam logic [1:0] C_ST_BLOCKED = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = C_ST_IDLE,
        ST_SEND    = C_ST_SEND,
        ST_BLOCKED = C_ST_BLOCKED
    } tx_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ni_sync_fifo.sv
// ============================================================================
// Module : ni_sync_fifo
// Brief  : Single-clock FIFO with wrap-bit pointers and a combinational head.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ni_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int C_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [C_AW:0]    r_wr_ptr;
    logic [C_AW:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Equal low bits with differing wrap bits means the writer lapped the reader.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[C_AW] != r_rd_ptr[C_AW]) &&
                     (r_wr_ptr[C_AW-1:0] == r_rd_ptr[C_AW-1:0]);
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_head  = r_mem[r_rd_ptr[C_AW-1:0]];

    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[C_AW-1:0]] <= i_data;
    end

endmodule

`default_nettype wire

// File: rtl/local_net_iface.sv
// ============================================================================
// Module : local_net_iface
// Brief  : PE <-> router LOCAL port interface: TX queue + injector FSM, RX
//          queue with address check. NI_STATS_EN adds flit counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module local_net_iface
    import local_net_iface_pkg::*;
#(
    parameter logic [2:0] NODE_ADDRESS = 3'b0,
    parameter int         TX_DEPTH     = 4,
    parameter int         RX_DEPTH     = 4,
    parameter logic [7:0] STALL_LIMIT  = 8'd255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     host_tx_valid,
    output logic                     host_tx_ready,
    input  logic [C_ADDR_W-1:0]      host_tx_dst,
    input  logic [C_DW-C_ADDR_W-1:0] host_tx_payload,
    output logic                     host_rx_valid,
    input  logic                     host_rx_ready,
    output logic [C_DW-1:0]          host_rx_data,
    output logic [C_DW-1:0]          net_data_out,
    output logic                     net_valid_out,
    input  logic                     net_full_in,
    input  logic [C_DW-1:0]          net_data_in,
    input  logic                     net_valid_in,
    output logic                     tx_stall_err,
    output logic                     rx_overflow,
`ifdef NI_STATS_EN
    output logic [15:0]              tx_flit_cnt,
    output logic [15:0]              rx_flit_cnt,
`endif
    output logic                     rx_misroute
);

    localparam int C_TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int C_RX_CW = $clog2(RX_DEPTH) + 1;

    tx_state_t          r_state;
    logic [7:0]         r_stall_cnt;
    logic [7:0]         w_stall_inc;
    logic               w_tx_push;
    logic               w_tx_full;
    logic               w_tx_empty;
    logic [C_DW-1:0]    w_tx_head;
    logic [C_TX_CW-1:0] w_tx_count;
    logic               w_rx_pop;
    logic               w_rx_full;
    logic               w_rx_empty;
    logic               w_rx_accept;
    logic [C_DW-1:0]    w_rx_head;
    logic [C_RX_CW-1:0] w_rx_count_unused;

    // ---------------- TX path ----------------
    assign host_tx_ready = !w_tx_full;
    assign w_tx_push     = host_tx_valid && !w_tx_full;
    assign net_valid_out = (r_state == ST_SEND) && !net_full_in && !w_tx_empty;
    assign net_data_out  = net_valid_out ? w_tx_head : '0;
    assign w_stall_inc   = sat_inc8(r_stall_cnt);

    ni_sync_fifo #(
        .WIDTH (C_DW),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_tx_push),
        .i_data  ({host_tx_payload, host_tx_dst}),
        .i_pop   (net_valid_out),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_head  (w_tx_head),
        .o_count (w_tx_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_stall_cnt  <= 8'd0;
            tx_stall_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_tx_empty) r_state <= net_full_in ? ST_BLOCKED : ST_SEND;
                end
                ST_SEND: begin
                    if (net_full_in && !w_tx_empty) begin
                        r_state <= ST_BLOCKED;
                    end else if (net_valid_out && (w_tx_count == C_TX_CW'(1)) && !w_tx_push) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BLOCKED: begin
                    if (net_full_in) begin
                        r_stall_cnt <= w_stall_inc;
                        if (w_stall_inc >= STALL_LIMIT) tx_stall_err <= 1'b1;
                    end else begin
                        r_state     <= ST_SEND;
                        r_stall_cnt <= 8'd0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // ---------------- RX path ----------------
    // A same-cycle host pop frees the slot, so the arriving flit still fits.
    assign w_rx_pop      = host_rx_ready && !w_rx_empty;
    assign w_rx_accept   = net_valid_in && (!w_rx_full || w_rx_pop);
    assign host_rx_valid = !w_rx_empty;
    assign host_rx_data  = w_rx_empty ? '0 : w_rx_head;

    ni_sync_fifo #(
        .WIDTH (C_DW),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (net_valid_in),
        .i_data  (net_data_in),
        .i_pop   (w_rx_pop),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_head  (w_rx_head),
        .o_count (w_rx_count_unused)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_overflow <= 1'b0;
            rx_misroute <= 1'b0;
        end else begin
            if (net_valid_in && !w_rx_accept) rx_overflow <= 1'b1;
            if (net_valid_in && (net_data_in[C_ADDR_W-1:0] != NODE_ADDRESS)) rx_misroute <= 1'b1;
        end
    end

`ifdef NI_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_flit_cnt <= 16'd0;
            rx_flit_cnt <= 16'd0;
        end else begin
            if (net_valid_out) tx_flit_cnt <= tx_flit_cnt + 16'd1;
            if (w_rx_accept)   rx_flit_cnt <= rx_flit_cnt + 16'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_local_net_iface.sv
// ============================================================================
// Module : tb_local_net_iface
// Brief  : Self-checking bench for local_net_iface against a queue-based model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module tb_local_net_iface;

    localparam int         DW   = `DATA_WIDTH;
    localparam int         PW   = DW - 3;
    localparam int         TXD  = 4;
    localparam int         RXD  = 4;
    localparam int         LIM  = 8;
    localparam logic [2:0] NODE = 3'd0;

    logic          clk = 1'b0;
    logic          rst;
    logic          host_tx_valid;
    logic          host_tx_ready;
    logic [2:0]    host_tx_dst;
    logic [PW-1:0] host_tx_payload;
    logic          host_rx_valid;
    logic          host_rx_ready;
    logic [DW-1:0] host_rx_data;
    logic [DW-1:0] net_data_out;
    logic          net_valid_out;
    logic          net_full_in;
    logic [DW-1:0] net_data_in;
    logic          net_valid_in;
    logic          tx_stall_err;
    logic          rx_overflow;
    logic          rx_misroute;
`ifdef NI_STATS_EN
    logic [15:0]   tx_flit_cnt;
    logic [15:0]   rx_flit_cnt;
`endif

    local_net_iface #(
        .NODE_ADDRESS (NODE),
        .TX_DEPTH     (TXD),
        .RX_DEPTH     (RXD),
        .STALL_LIMIT  (8'(LIM))
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .host_tx_valid   (host_tx_valid),
        .host_tx_ready   (host_tx_ready),
        .host_tx_dst     (host_tx_dst),
        .host_tx_payload (host_tx_payload),
        .host_rx_valid   (host_rx_valid),
        .host_rx_ready   (host_rx_ready),
        .host_rx_data    (host_rx_data),
        .net_data_out    (net_data_out),
        .net_valid_out   (net_valid_out),
        .net_full_in     (net_full_in),
        .net_data_in     (net_data_in),
        .net_valid_in    (net_valid_in),
        .tx_stall_err    (tx_stall_err),
        .rx_overflow     (rx_overflow),
`ifdef NI_STATS_EN
        .tx_flit_cnt     (tx_flit_cnt),
        .rx_flit_cnt     (rx_flit_cnt),
`endif
        .rx_misroute     (rx_misroute)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: queued flits, the injector's engagement, and sticky flags.
    logic [DW-1:0] txq[$];
    logic [DW-1:0] rxq[$];
    logic [DW-1:0] inj_log[$];
    bit            engaged;
    bit            held;
    int            run;
    bit            m_stall, m_ovf, m_mis;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        txq.delete();
        rxq.delete();
        engaged = 0;
        held    = 0;
        run     = 0;
        m_stall = 0;
        m_ovf   = 0;
        m_mis   = 0;
    endtask

    task automatic clear_inputs();
        host_tx_valid   = 0;
        host_tx_dst     = '0;
        host_tx_payload = '0;
        host_rx_ready   = 0;
        net_full_in     = 0;
        net_data_in     = '0;
        net_valid_in    = 0;
    endtask

    // One clock: compare outputs with the model, advance the model, move to next negedge.
    task automatic step();
        bit            exp_valid;
        bit            push;
        logic [DW-1:0] exp_data;
        logic [DW-1:0] exp_rx;
        #1;
        exp_valid = engaged && !held && !net_full_in && (txq.size() > 0);
        exp_data  = '0;
        if (exp_valid) exp_data = txq[0];
        exp_rx = '0;
        if (rxq.size() > 0) exp_rx = rxq[0];
        chk("tx_ready",  64'(host_tx_ready), 64'(txq.size() < TXD));
        chk("net_valid", 64'(net_valid_out), 64'(exp_valid));
        chk("net_data",  64'(net_data_out),  64'(exp_data));
        chk("rx_valid",  64'(host_rx_valid), 64'(rxq.size() > 0));
        chk("rx_data",   64'(host_rx_data),  64'(exp_rx));
        chk("stall_err", 64'(tx_stall_err),  64'(m_stall));
        chk("overflow",  64'(rx_overflow),   64'(m_ovf));
        chk("misroute",  64'(rx_misroute),   64'(m_mis));

        push = host_tx_valid && (txq.size() < TXD);
        if (!engaged) begin
            if (txq.size() > 0) begin
                engaged = 1;
                held    = net_full_in;
            end
        end else if (held) begin
            if (net_full_in) begin
                if (run < 255) run++;
                if (run >= LIM) m_stall = 1;
            end else begin
                held = 0;
                run  = 0;
            end
        end else if (net_full_in) begin
            held = 1;
        end else if (exp_valid) begin
            inj_log.push_back(txq.pop_front());
            if (txq.size() == 0 && !push) engaged = 0;
        end
        if (push) txq.push_back({host_tx_payload, host_tx_dst});

        if (host_rx_ready && rxq.size() > 0) void'(rxq.pop_front());
        if (net_valid_in) begin
            if (net_data_in[2:0] != NODE) m_mis = 1;
            if (rxq.size() < RXD) rxq.push_back(net_data_in);
            else m_ovf = 1;
        end
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear at once.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1;
        #1;
        chk("rst_tx_ready",  64'(host_tx_ready), 64'd1);
        chk("rst_net_valid", 64'(net_valid_out), 64'd0);
        chk("rst_net_data",  64'(net_data_out),  64'd0);
        chk("rst_rx_valid",  64'(host_rx_valid), 64'd0);
        chk("rst_rx_data",   64'(host_rx_data),  64'd0);
        chk("rst_stall",     64'(tx_stall_err),  64'd0);
        chk("rst_overflow",  64'(rx_overflow),   64'd0);
        chk("rst_misroute",  64'(rx_misroute),   64'd0);
        model_reset();
        clear_inputs();
        @(negedge clk);
        rst = 0;
    endtask

    logic [63:0] t2_exp [4] = '{64'h81, 64'h8A, 64'h93, 64'h9C};

    initial begin
        rst = 1;
        clear_inputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("reset_tx_ready",  64'(host_tx_ready), 64'd1);
        chk("reset_net_valid", 64'(net_valid_out), 64'd0);
        chk("reset_rx_valid",  64'(host_rx_valid), 64'd0);
        rst = 0;

        // Single flit dst=3 payload=5.
        host_tx_valid = 1; host_tx_dst = 3'd3; host_tx_payload = PW'(5);
        step();
        host_tx_valid = 0;
        step();
        chk("t1_valid", 64'(net_valid_out), 64'd1);
        chk("t1_data",  64'(net_data_out),  64'h2B);
        step();
        step();
        chk("t1_idle",  64'(net_valid_out), 64'd0);

        // Burst of four held behind back-pressure, then released in order.
        net_full_in = 1;
        for (int i = 0; i < 4; i++) begin
            host_tx_valid = 1; host_tx_dst = 3'(i + 1); host_tx_payload = PW'(16 + i);
            step();
        end
        host_tx_valid = 0;
        chk("t2_ready_low", 64'(host_tx_ready), 64'd0);
        inj_log.delete();
        net_full_in = 0;
        repeat (6) step();
        chk("t2_count", 64'(inj_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < inj_log.size(); i++) chk("t2_order", 64'(inj_log[i]), t2_exp[i]);

        // Back-pressure for 10 cycles mid-burst.
        inj_log.delete();
        for (int i = 0; i < 4; i++) begin
            host_tx_valid = 1; host_tx_dst = 3'(i); host_tx_payload = PW'(32 + i);
            step();
        end
        host_tx_valid = 0;
        step();
        net_full_in = 1;
        repeat (10) begin
            step();
            chk("t3_hold", 64'(net_valid_out), 64'd0);
        end
        net_full_in = 0;
        repeat (8) step();
        chk("t3_count", 64'(inj_log.size()), 64'd4);

        // Stall error after the 8th blocked cycle.
        do_reset();
        net_full_in = 1;
        host_tx_valid = 1; host_tx_dst = 3'd2; host_tx_payload = PW'(7);
        step();
        host_tx_valid = 0;
        step();
        repeat (7) step();
        chk("t4_not_yet", 64'(tx_stall_err), 64'd0);
        step();
        chk("t4_set", 64'(tx_stall_err), 64'd1);
        net_full_in = 0;
        repeat (3) step();
        chk("t4_sticky", 64'(tx_stall_err), 64'd1);

        // RX overflow on the 5th flit, then a misrouted flit.
        net_valid_in = 1;
        for (int i = 0; i < 5; i++) begin
            net_data_in = {PW'(i + 1), 3'd0};
            step();
            if (i == 3) chk("t5_no_ovf", 64'(rx_overflow), 64'd0);
        end
        chk("t5_ovf", 64'(rx_overflow), 64'd1);
        chk("t5_mis_clear", 64'(rx_misroute), 64'd0);
        net_data_in = {PW'(9), 3'd6};
        step();
        net_valid_in = 0;
        chk("t5_mis", 64'(rx_misroute), 64'd1);
        chk("t5_head", 64'(host_rx_data), 64'h8);

        // Reset while blocked with three flits queued.
        net_full_in = 1;
        for (int i = 0; i < 3; i++) begin
            host_tx_valid = 1; host_tx_dst = 3'(i); host_tx_payload = PW'(40 + i);
            step();
        end
        host_tx_valid = 0;
        step();
        chk("t6_queued", 64'(host_tx_ready), 64'd1);
        do_reset();

        // Randomized traffic with bursty back-pressure.
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            if ($urandom_range(0, 9) == 0) net_full_in = ~net_full_in;
            host_tx_valid   = ($urandom_range(0, 9) < 7);
            host_tx_dst     = 3'($urandom);
            host_tx_payload = PW'($urandom);
            net_valid_in    = ($urandom_range(0, 1) == 1);
            net_data_in     = {PW'($urandom), ($urandom_range(0, 15) == 0) ? 3'($urandom) : NODE};
            host_rx_ready   = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
